npc_lsu: RTL and testbench
==========================

// Module: npc_lsu
// PURPOSE
//  Load/store unit of the NPC core: the memory-side responder for the decoder's memory commands.
//  Accepts one load/store command (mem_ctrl, addr, wdata) per transaction and drives one
//  64-bit-wide data-bus request with byte lanes, write data and write mask.
//  Returns the load result sign/zero-extended to XLEN, or a store acknowledge.
//  Misaligned accesses are rejected with an error and never issue a bus request.
// PARAMETERS
//  XLEN    64  data/address width; bus is XLEN wide, XLEN/8 byte lanes
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     synchronous active-low reset
//  req_valid      in   1     command valid from decode/execute
//  req_ready      out  1     high only in IDLE
//  mem_ctrl       in   4     [3]=store; [2:0]=size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//  addr           in   XLEN  byte address (rs1+imm)
//  wdata          in   XLEN  store data, right-aligned (rs2)
//  resp_valid     out  1     result valid; held until resp_ready
//  resp_ready     in   1     consumer accepts result
//  resp_rdata     out  XLEN  extended load data; 0 for stores and errors
//  resp_err       out  1     misaligned access, or encoding 111
//  bus_req_valid  out  1     bus request valid
//  bus_req_ready  in   1     bus accepts request
//  bus_req_wen    out  1     1 = write
//  bus_req_addr   out  XLEN  addr with low log2(XLEN/8) bits cleared
//  bus_req_wdata  out  XLEN  wdata shifted into its byte lanes
//  bus_req_wmask  out  XLEN/8  byte-enable mask (reads: 0)
//  bus_rsp_valid  in   1     bus response (read data or write ack); one-cycle pulse
//  bus_rsp_rdata  in   XLEN  full aligned bus word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 after reset; all other outputs 0; latched command cleared.
//  FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: req_ready=1. On req_valid, latch mem_ctrl/addr/wdata; bus_rsp_valid is ignored in this state.
//     aligned & legal -> REQ; misaligned or 111 -> DONE with resp_err=1.
//   REQ : bus_req_valid=1; addr/wen/wdata/wmask stable until bus_req_ready; then -> WAIT.
//   WAIT: on bus_rsp_valid, capture extended result -> DONE. No timeout.
//   DONE: resp_valid=1, outputs stable; on resp_ready -> IDLE (earliest next accept is the following cycle).
//  Min latency (bus ready and responds next cycle): accept T0, bus_req T1, rsp T2, resp_valid T3.
//  Error path: accept T0, resp_valid+resp_err at T1.
//  Alignment: h needs addr[0]=0; w needs addr[1:0]=0; d needs addr[2:0]=0.
//  Lanes: off=addr[2:0]; wmask = ((1<<bytes)-1)<<off; bus_req_wdata = wdata<<(8*off).
//  Load: field = bus_rsp_rdata>>(8*off), truncated to size;
//    sign-extend for b/h/w; zero-extend for bu/hu/wu; d passes through.
//  Only one transaction is outstanding at a time; no request is issued while in WAIT/DONE.
//  Reset asserted in any state -> IDLE on that edge; a bus response arriving afterwards is dropped.
// TESTING
//  lw (0010) addr 0x80000004, rsp 0x8765432112345678 -> bus addr 0x80000000, wmask 0x00,
//    resp_rdata 0xFFFFFFFF87654321, resp_valid at T3.
//  lwu (0110), same stimulus -> resp_rdata 0x0000000087654321.
//  sb (1000) addr 0x80000003, wdata 0x...AB -> wmask 0x08, wdata 0x00000000AB000000,
//    wen=1; after ack: resp_rdata 0, err 0.
//  lh (0001) addr 0x80000001 -> bus_req_valid never rises; resp_valid+resp_err=1 one cycle after accept.
//  sd with bus_req_ready low 3 cycles, resp_ready low 2 cycles -> bus request and resp outputs
//    held stable; req_ready=0 throughout.
//  lb (0000) to lane 7 with data 0x80; rst_n low during WAIT, then rsp pulse -> IDLE, resp_valid stays 0;
//    re-issue lb and lbu -> 0xFFFFFFFFFFFFFF80 and 0x80.

Source files
------------

// File: rtl/npc_lsu.sv
// npc_lsu: load/store unit issuing one aligned, lane-masked bus request per command
// and returning the extended load result, a store acknowledge, or a misalignment error.
module npc_lsu #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          mem_ctrl,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_wen,
    output logic [XLEN-1:0]     bus_req_addr,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_wmask,
    input  logic                bus_rsp_valid,
    input  logic [XLEN-1:0]     bus_rsp_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic [3:0]      cmd;
    logic [OW-1:0]   off;
    logic [OW-1:0]   in_off;
    logic [1:0]      in_size;
    logic            bad;
    logic [NB-1:0]   in_mask;
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] load_data;
    logic            sx;

    always_comb begin
        in_off    = addr[OW-1:0];
        in_size   = mem_ctrl[1:0];
        bad       = (mem_ctrl[2:0] == 3'b111) ||
                    (in_size == 2'd1 && addr[0]) ||
                    (in_size == 2'd2 && |addr[1:0]) ||
                    (in_size == 2'd3 && |addr[2:0]);
        in_mask   = ((NB'(1) << (1 << in_size)) - NB'(1)) << in_off;
        field     = bus_rsp_rdata >> {off, 3'b000};
        sx        = ~cmd[2];
        load_data = cmd[1:0] == 2'd0 ? {{(XLEN-8){sx & field[7]}}, field[7:0]} :
                    cmd[1:0] == 2'd1 ? {{(XLEN-16){sx & field[15]}}, field[15:0]} :
                    cmd[1:0] == 2'd2 ? {{(XLEN-32){sx & field[31]}}, field[31:0]} : field;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            cmd           <= '0;
            off           <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_wen   <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_wmask <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cmd       <= mem_ctrl;
                    off       <= in_off;
                    req_ready <= 1'b0;
                    if (bad) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state         <= REQ;
                        bus_req_valid <= 1'b1;
                        bus_req_wen   <= mem_ctrl[3];
                        bus_req_addr  <= {addr[XLEN-1:OW], {OW{1'b0}}};
                        bus_req_wdata <= mem_ctrl[3] ? wdata << {in_off, 3'b000} : '0;
                        bus_req_wmask <= mem_ctrl[3] ? in_mask : '0;
                    end
                end
                REQ: if (bus_req_ready) begin
                    state         <= WAIT;
                    bus_req_valid <= 1'b0;
                end
                WAIT: if (bus_rsp_valid) begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= cmd[3] ? '0 : load_data;
                end
                DONE: if (resp_ready) begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed bench for npc_lsu covering loads, stores, errors, stalls and mid-flight reset.
module tb_npc_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  mem_ctrl;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_wen;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_rsp_valid;
    logic [63:0] bus_rsp_rdata;
    int          checks = 0;
    int          errors = 0;

    npc_lsu #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_wen(bus_req_wen), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        mem_ctrl  = c;
        addr      = a;
        wdata     = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [63:0] d);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = d;
        tick();
        bus_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_ctrl = '0; addr = '0; wdata = '0;
        resp_ready = 1'b0; bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        repeat (2) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_wmask", 64'(bus_req_wmask), 64'd0);
        rst_n = 1'b1;
        tick();

        // lw: T1 request, T2 wait, T3 result
        issue(4'b0010, 64'h80000004, 64'd0);
        chk("lw_bus_valid", 64'(bus_req_valid), 64'd1);
        chk("lw_bus_addr", bus_req_addr, 64'h80000000);
        chk("lw_wmask", 64'(bus_req_wmask), 64'd0);
        chk("lw_wen", 64'(bus_req_wen), 64'd0);
        chk("lw_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("lw_t2_bus_valid", 64'(bus_req_valid), 64'd0);
        chk("lw_t2_resp_valid", 64'(resp_valid), 64'd0);
        respond(64'h8765432112345678);
        chk("lw_resp_valid", 64'(resp_valid), 64'd1);
        chk("lw_rdata", resp_rdata, 64'hFFFFFFFF87654321);
        chk("lw_err", 64'(resp_err), 64'd0);
        consume();
        chk("lw_idle_valid", 64'(resp_valid), 64'd0);
        chk("lw_idle_ready", 64'(req_ready), 64'd1);

        issue(4'b0110, 64'h80000004, 64'd0);
        tick();
        respond(64'h8765432112345678);
        chk("lwu_rdata", resp_rdata, 64'h0000000087654321);
        consume();

        issue(4'b1000, 64'h80000003, 64'h00000000000000AB);
        chk("sb_wmask", 64'(bus_req_wmask), 64'h08);
        chk("sb_wdata", bus_req_wdata, 64'h00000000AB000000);
        chk("sb_wen", 64'(bus_req_wen), 64'd1);
        chk("sb_addr", bus_req_addr, 64'h80000000);
        tick();
        respond(64'hDEADBEEFCAFEF00D);
        chk("sb_resp_valid", 64'(resp_valid), 64'd1);
        chk("sb_rdata", resp_rdata, 64'd0);
        chk("sb_err", 64'(resp_err), 64'd0);
        consume();

        // misaligned halfword never reaches the bus
        issue(4'b0001, 64'h80000001, 64'd0);
        chk("lh_resp_valid", 64'(resp_valid), 64'd1);
        chk("lh_err", 64'(resp_err), 64'd1);
        chk("lh_bus_valid", 64'(bus_req_valid), 64'd0);
        chk("lh_rdata", resp_rdata, 64'd0);
        consume();
        chk("lh_idle_bus_valid", 64'(bus_req_valid), 64'd0);
        chk("lh_idle_err", 64'(resp_err), 64'd0);

        issue(4'b0111, 64'h80000000, 64'd0);
        chk("enc111_err", 64'(resp_err), 64'd1);
        chk("enc111_bus_valid", 64'(bus_req_valid), 64'd0);
        consume();

        // sd with stalled bus and stalled consumer
        bus_req_ready = 1'b0;
        issue(4'b1011, 64'h80000008, 64'h0123456789ABCDEF);
        for (int i = 0; i < 3; i++) begin
            chk("sd_stall_valid", 64'(bus_req_valid), 64'd1);
            chk("sd_stall_addr", bus_req_addr, 64'h80000008);
            chk("sd_stall_wdata", bus_req_wdata, 64'h0123456789ABCDEF);
            chk("sd_stall_wmask", 64'(bus_req_wmask), 64'hFF);
            chk("sd_stall_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        chk("sd_still_valid", 64'(bus_req_valid), 64'd1);
        bus_req_ready = 1'b1;
        tick();
        chk("sd_sent", 64'(bus_req_valid), 64'd0);
        respond(64'd0);
        for (int i = 0; i < 2; i++) begin
            chk("sd_hold_valid", 64'(resp_valid), 64'd1);
            chk("sd_hold_err", 64'(resp_err), 64'd0);
            chk("sd_hold_rdata", resp_rdata, 64'd0);
            chk("sd_hold_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        consume();
        chk("sd_idle_ready", 64'(req_ready), 64'd1);

        // reset while waiting drops the late response
        issue(4'b0000, 64'h80000007, 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_wait_ready", 64'(req_ready), 64'd1);
        chk("rst_wait_valid", 64'(resp_valid), 64'd0);
        respond(64'h8000000000000000);
        chk("late_rsp_valid", 64'(resp_valid), 64'd0);
        chk("late_rsp_ready", 64'(req_ready), 64'd1);
        chk("late_rsp_bus_valid", 64'(bus_req_valid), 64'd0);

        issue(4'b0000, 64'h80000007, 64'd0);
        tick();
        respond(64'h8000000000000000);
        chk("lb_rdata", resp_rdata, 64'hFFFFFFFFFFFFFF80);
        consume();
        issue(4'b0100, 64'h80000007, 64'd0);
        tick();
        respond(64'h8000000000000000);
        chk("lbu_rdata", resp_rdata, 64'h0000000000000080);
        consume();

        issue(4'b0001, 64'h80000006, 64'd0);
        tick();
        respond(64'h9ABC000000000000);
        chk("lh_lane6_rdata", resp_rdata, 64'hFFFFFFFFFFFF9ABC);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
